// File: rtl/i2s_adc_rx_if.sv
// i2s_adc_rx_if: valid/ready stream carrying one captured left/right sample pair.
interface i2s_adc_rx_if #(
   parameter int DATA_WIDTH = 24
);
   logic [DATA_WIDTH-1:0] out_left;
   logic [DATA_WIDTH-1:0] out_right;
   logic                  out_valid;
   logic                  out_ready;
   modport master (output out_left, output out_right, output out_valid, input out_ready);
   modport slave  (input out_left, input out_right, input out_valid, output out_ready);
endinterface

// File: rtl/i2s_adc_rx.sv
// i2s_adc_rx: deserializes the codec I2S ADC stream into left/right pairs on a valid/ready stream.
module i2s_adc_rx #(
   parameter int DATA_WIDTH  = 24,
   parameter int SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   input  logic aud_bclk,
   input  logic aud_adclrck,
   input  logic aud_adcdat,
   input  logic overflow_clr,
   output logic overflow,
   i2s_adc_rx_if.master pair_o
);
   localparam int CW = $clog2(DATA_WIDTH + 1);
   typedef enum logic [1:0] {IDLE, SKIP, SHIFT, WAIT} state_t;
   state_t                  state_q, state_d;
   logic [SYNC_STAGES-1:0]  bclk_sq, lr_sq, dat_sq;
   logic                    bclk_pq, lr_pq;
   logic                    chan_q, chan_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0]   sr_q, sr_d, word, left_q, out_left_q, out_right_q;
   logic                    valid_q, ovf_q, commit, load;
   wire bclk_s    = bclk_sq[SYNC_STAGES-1];
   wire lr_s      = lr_sq[SYNC_STAGES-1];
   wire dat_s     = dat_sq[SYNC_STAGES-1];
   wire bclk_rise = bclk_s & ~bclk_pq;
   wire lr_fall   = ~lr_s & lr_pq;
   wire lr_rise   = lr_s & ~lr_pq;
   wire opp       = chan_q ? lr_fall : lr_rise;
   wire same      = chan_q ? lr_rise : lr_fall;
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bclk_sq <= '0;
         lr_sq   <= '0;
         dat_sq  <= '0;
         bclk_pq <= 1'b0;
         lr_pq   <= 1'b0;
         state_q <= IDLE;
         chan_q  <= 1'b0;
         cnt_q   <= '0;
         sr_q    <= '0;
      end else begin
         bclk_sq <= {bclk_sq[SYNC_STAGES-2:0], aud_bclk};
         lr_sq   <= {lr_sq[SYNC_STAGES-2:0], aud_adclrck};
         dat_sq  <= {dat_sq[SYNC_STAGES-2:0], aud_adcdat};
         bclk_pq <= bclk_s;
         lr_pq   <= lr_s;
         state_q <= state_d;
         chan_q  <= chan_d;
         cnt_q   <= cnt_d;
         sr_q    <= sr_d;
      end
   end
   // A word-clock edge before the delay bit is taken as a glitch and drops sync.
   always_comb begin
      state_d = state_q;
      chan_d  = chan_q;
      cnt_d   = cnt_q;
      sr_d    = sr_q;
      commit  = 1'b0;
      word    = sr_q;
      if (!enable) state_d = IDLE;
      else case (state_q)
         IDLE: if (lr_fall) begin
            state_d = SKIP;
            chan_d  = 1'b0;
         end
         SKIP: if (lr_fall || lr_rise) state_d = IDLE;
         else if (bclk_rise) begin
            sr_d    = '0;
            cnt_d   = '0;
            state_d = SHIFT;
         end
         SHIFT: if (opp) begin
            commit  = 1'b1;
            word    = sr_q << (DATA_WIDTH - int'(cnt_q));
            chan_d  = ~chan_q;
            state_d = SKIP;
         end else if (same) state_d = IDLE;
         else if (bclk_rise) begin
            sr_d  = DATA_WIDTH'({sr_q, dat_s});
            cnt_d = cnt_q + CW'(1);
            if (cnt_d == CW'(DATA_WIDTH)) begin
               commit  = 1'b1;
               word    = sr_d;
               state_d = WAIT;
            end
         end
         WAIT: if (opp) begin
            chan_d  = ~chan_q;
            state_d = SKIP;
         end else if (same) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   assign load = commit & chan_q & (~valid_q | pair_o.out_ready);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         left_q      <= '0;
         out_left_q  <= '0;
         out_right_q <= '0;
         valid_q     <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         if (commit && !chan_q) left_q <= word;
         if (load) begin
            out_left_q  <= left_q;
            out_right_q <= word;
            valid_q     <= 1'b1;
         end else if (valid_q && pair_o.out_ready) valid_q <= 1'b0;
         ovf_q <= (commit & chan_q & ~load) | (ovf_q & ~overflow_clr);
      end
   end
   assign pair_o.out_left  = out_left_q;
   assign pair_o.out_right = out_right_q;
   assign pair_o.out_valid = valid_q;
   assign overflow         = ovf_q;
endmodule

// File: tb/tb_i2s_adc_rx.sv
// tb_i2s_adc_rx: codec-master I2S stimulus with a frame-level model feeding a scoreboard.
module tb_i2s_adc_rx;
   logic clk = 0, reset = 1, enable = 1, aud_bclk = 0, aud_adclrck = 0, aud_adcdat = 0;
   logic overflow_clr = 0, overflow;
   logic [47:0] q[$];
   int n_cmp = 0, n_bad = 0, n_got = 0, n0;
   bit exp_ovf = 0;
   i2s_adc_rx_if #(.DATA_WIDTH(24)) bus();
   i2s_adc_rx #(.DATA_WIDTH(24), .SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .enable(enable), .aud_bclk(aud_bclk),
      .aud_adclrck(aud_adclrck), .aud_adcdat(aud_adcdat),
      .overflow_clr(overflow_clr), .overflow(overflow), .pair_o(bus)
   );
   always #10 clk = ~clk;
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask
   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         n_got++;
         if (q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL unexpected pair: got %h/%h expected none", bus.out_left, bus.out_right);
         end else check("pair", {bus.out_left, bus.out_right}, q.pop_front());
      end
   end
   task automatic bclk_cycle(input bit d, input bit g);
      aud_adcdat = d;
      if (g) begin
         aud_adclrck = ~aud_adclrck;
         step(3);
         aud_adclrck = ~aud_adclrck;
         step(7);
      end else step(10);
      aud_bclk = 1;
      step(10);
      aud_bclk = 0;
   endtask
   // act: 1 = reset pulse, 2 = enable drop, 3 = release reset
   task automatic send_word(input bit lr, input logic [31:0] w, input int nbits, input int total,
                            input bit pad, input int g_at, input int act_at, input int act);
      aud_adclrck = lr;
      for (int i = 0; i < total; i++) begin
         if (i == act_at) begin
            if (act == 1) begin
               reset = 1;
               step(2);
               reset = 0;
               exp_ovf = 0;
               check("abort reset valid", bus.out_valid, 0);
            end else if (act == 2) begin
               enable = 0;
               step(3);
               enable = 1;
            end else reset = 0;
         end
         bclk_cycle((i >= 1 && i <= nbits) ? w[nbits-i] : pad, i == g_at);
      end
   endtask
   task automatic send_frame(input logic [31:0] l, input logic [31:0] r, input int nbits,
                             input int total, input bit pad);
      logic [23:0] el, er;
      el = 24'(64'(l) << (24 - nbits));
      er = 24'(64'(r) << (24 - nbits));
      if (!bus.out_ready && q.size() > 0) exp_ovf = 1;
      else q.push_back({el, er});
      send_word(0, l, nbits, total, pad, -1, -1, 0);
      send_word(1, r, nbits, total, pad, -1, -1, 0);
   endtask
   function automatic logic [31:0] rnd(input int n);
      return $urandom & ((32'd1 << n) - 1);
   endfunction
   task automatic phase_start();
      reset = 1;
      exp_ovf = 0;
      aud_adclrck = 0;
      step(3);
      send_word(1, rnd(24), 24, 32, 0, -1, 8, 3);
      n0 = n_got;
   endtask
   task automatic drain(input string name, input int n);
      for (int i = 0; i < 200 && q.size() > 0; i++) step(1);
      step(20);
      check({name, " pending"}, 48'(q.size()), 0);
      check({name, " count"}, 48'(n_got - n0), 48'(n));
      check({name, " overflow"}, overflow, exp_ovf);
   endtask
   initial begin
      bus.out_ready = 1;
      step(2);
      check("reset valid", bus.out_valid, 0);
      check("reset left", bus.out_left, 0);
      check("reset right", bus.out_right, 0);
      check("reset overflow", overflow, 0);
      phase_start();
      send_frame(32'hA5A5A5, 32'h5A5A5A, 24, 32, 1);
      repeat (3) send_frame(rnd(24), rnd(24), 24, 32, 1);
      drain("nominal", 4);
      phase_start();
      repeat (2) send_frame(rnd(24), rnd(24), 24, 32, 0);
      drain("midstart", 2);
      phase_start();
      bus.out_ready = 0;
      send_frame(1, 2, 24, 32, 1);
      send_frame(3, 4, 24, 32, 1);
      check("bp overflow f2", overflow, exp_ovf);
      send_frame(5, 6, 24, 32, 1);
      check("bp valid held", bus.out_valid, 1);
      check("bp held pair", {bus.out_left, bus.out_right}, 48'h000001_000002);
      check("bp overflow f3", overflow, exp_ovf);
      bus.out_ready = 1;
      step(2);
      overflow_clr = 1;
      exp_ovf = 0;
      step(1);
      overflow_clr = 0;
      check("bp overflow clr", overflow, exp_ovf);
      send_frame(7, 8, 24, 32, 1);
      drain("backpressure", 2);
      phase_start();
      send_frame(32'h1234, 32'hBEEF, 16, 17, 0);
      send_frame(rnd(16), rnd(16), 16, 17, 1);
      send_word(0, 0, 0, 3, 0, -1, -1, 0);
      drain("short", 2);
      phase_start();
      send_frame(rnd(24), rnd(24), 24, 32, 1);
      send_word(0, rnd(24), 24, 32, 1, -1, 11, 1);
      send_word(1, rnd(24), 24, 32, 1, -1, -1, 0);
      send_frame(rnd(24), rnd(24), 24, 32, 1);
      drain("reset abort", 2);
      phase_start();
      send_frame(rnd(24), rnd(24), 24, 32, 1);
      send_word(0, rnd(24), 24, 32, 1, -1, 11, 2);
      send_word(1, rnd(24), 24, 32, 1, -1, -1, 0);
      send_frame(rnd(24), rnd(24), 24, 32, 1);
      drain("enable abort", 2);
      phase_start();
      send_frame(rnd(24), rnd(24), 24, 32, 1);
      send_word(0, rnd(24), 24, 32, 1, 26, -1, 0);
      send_word(1, rnd(24), 24, 32, 1, -1, -1, 0);
      send_frame(rnd(24), rnd(24), 24, 32, 1);
      drain("lost sync", 2);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
